cache_op_sequencer: RTL and testbench

Sequences one cache operation at a time between the register interface and the key-value storage. On a start pulse it latches operation, key and data from the register block, runs a request/acknowledge transaction on the storage port, then writes busy, hit, data and a cleared operation back. It sits between the register front-end (reg_read_t / reg_write_t from if_types_pkg) and the storage array.

---
 rtl/ctrl_types_pkg.sv | 13 +
 rtl/if_types_pkg.sv | 34 +++
 rtl/cache_op_seq_watchdog.sv | 30 +++
 rtl/cache_op_sequencer.sv | 149 ++++++++++++++
 tb/tb_cache_op_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_types_pkg.sv
// Control-side types: state encodings and default parameters for the
// sequencer FSMs.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } cache_op_seq_state_e;

  localparam int unsigned CacheOpSeqTimeoutDefault = 16;

endpackage

// File: rtl/if_types_pkg.sv
// Register-interface types shared between the register front-end and the
// storage-side sequencers: operation codes, field widths, read/write bundles.
package if_types_pkg;

  localparam int RegKeyWidth  = 32;
  localparam int RegDataWidth = 64;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  // Fields the register block presents to the sequencer.
  typedef struct packed {
    logic [RegDataWidth-1:0] dat;
    logic [RegKeyWidth-1:0]  key;
    operation_e              operation;
  } reg_read_t;

  // Register updates; each field only takes effect with its *_valid bit set.
  typedef struct packed {
    logic                    busy;
    logic                    busy_valid;
    logic                    hit;
    logic                    hit_valid;
    logic [RegDataWidth-1:0] dat;
    logic                    data_valid;
    operation_e              operation;
    logic                    operation_valid;
  } reg_write_t;

endpackage

// File: rtl/cache_op_seq_watchdog.sv
// Wait-cycle counter for the REQ state. Cleared on REQ entry, advanced on
// every REQ cycle without an acknowledge, expired at TimeoutCycles-1.
module cache_op_seq_watchdog #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntWidth-1:0] count_q;

  assign expired = (count_q == CntWidth'(TimeoutCycles - 1));

  // Counter saturates at the terminal value; the FSM aborts on that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/cache_op_sequencer.sv
// Sequences a single cache operation between the register block and the
// key-value storage: latch on start, request/ack on the storage port, then
// write busy/hit/data/operation back to the registers.
// Optional feature: define CACHE_OP_SEQ_TIMEOUT_EN to abort a REQ that sees
// no acknowledge within TimeoutCycles cycles.
//
// state | meaning
// IDLE  | waiting for a start pulse with a non-NOOP operation
// REQ   | storage request asserted, waiting for mem_ack_i
// DONE  | one cycle: write results back to the registers
module cache_op_sequencer
  import if_types_pkg::*;
  import ctrl_types_pkg::*;
#(
  parameter int unsigned TimeoutCycles = CacheOpSeqTimeoutDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  reg_read_t               reg_i,
  output reg_write_t              reg_o,
  output logic                    mem_req_o,
  output operation_e              mem_op_o,
  output logic [RegKeyWidth-1:0]  mem_key_o,
  output logic [RegDataWidth-1:0] mem_data_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_hit_i,
  input  logic [RegDataWidth-1:0] mem_data_i,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  if (TimeoutCycles < 2) begin : g_timeout_check
    $error("TimeoutCycles must be at least 2");
  end

  cache_op_seq_state_e     state_q, state_d;
  operation_e              op_d;
  logic [RegKeyWidth-1:0]  key_d;
  logic [RegDataWidth-1:0] data_d;
  logic                    req_d;
  reg_write_t              reg_d;
  logic                    busy_d;
  logic                    overrun_d;
  logic                    timeout_d;
  logic                    wd_expired;

`ifdef CACHE_OP_SEQ_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state_q == IDLE) && (state_d == REQ);
  assign wd_enable = (state_q == REQ) && !mem_ack_i;

  cache_op_seq_watchdog #(
    .TimeoutCycles (TimeoutCycles)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_d   = state_q;
    op_d      = mem_op_o;
    key_d     = mem_key_o;
    data_d    = mem_data_o;
    req_d     = 1'b0;
    reg_d     = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && (reg_i.operation != NOOP)) begin
          state_d          = REQ;
          op_d             = reg_i.operation;
          key_d            = reg_i.key;
          data_d           = reg_i.dat;
          req_d            = 1'b1;
          reg_d.busy       = 1'b1;
          reg_d.busy_valid = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d               = DONE;
          reg_d.busy_valid      = 1'b1;
          reg_d.hit             = mem_hit_i;
          reg_d.hit_valid       = 1'b1;
          reg_d.operation       = NOOP;
          reg_d.operation_valid = 1'b1;
          if (mem_op_o == READ) begin
            reg_d.data_valid = 1'b1;
            reg_d.dat        = mem_hit_i ? mem_data_i : '0;
          end
        end else if (wd_expired) begin
          state_d               = DONE;
          reg_d.busy_valid      = 1'b1;
          reg_d.hit_valid       = 1'b1;
          reg_d.operation       = NOOP;
          reg_d.operation_valid = 1'b1;
          timeout_d             = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    overrun_d = start_i && (state_q != IDLE);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mem_op_o   <= NOOP;
      mem_key_o  <= '0;
      mem_data_o <= '0;
      mem_req_o  <= 1'b0;
      reg_o      <= '0;
      busy_o     <= 1'b0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_op_o   <= op_d;
      mem_key_o  <= key_d;
      mem_data_o <= data_d;
      mem_req_o  <= req_d;
      reg_o      <= reg_d;
      busy_o     <= busy_d;
      overrun_o  <= overrun_d;
      timeout_o  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cache_op_sequencer.sv
// Directed testbench for cache_op_sequencer with a scoreboard of expected
// DONE-cycle register writes. Works with and without CACHE_OP_SEQ_TIMEOUT_EN.
module tb_cache_op_sequencer;
  import if_types_pkg::*;

  localparam int unsigned T = 4;
  localparam int NoAck = 1000;
  localparam int NoOv  = -10;
`ifdef CACHE_OP_SEQ_TIMEOUT_EN
  localparam int AbortIdx = T - 1;
`else
  localparam int AbortIdx = NoAck + 1;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    start_i;
  reg_read_t               reg_i;
  reg_write_t              reg_o;
  logic                    mem_req_o;
  operation_e              mem_op_o;
  logic [RegKeyWidth-1:0]  mem_key_o;
  logic [RegDataWidth-1:0] mem_data_o;
  logic                    mem_ack_i;
  logic                    mem_hit_i;
  logic [RegDataWidth-1:0] mem_data_i;
  logic                    busy_o;
  logic                    overrun_o;
  logic                    timeout_o;

  int         n_tests = 0;
  int         n_fail  = 0;
  reg_write_t exp_q[$];

  always #5 clk_i = ~clk_i;

  cache_op_sequencer #(.TimeoutCycles(T)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .reg_i      (reg_i),
    .reg_o      (reg_o),
    .mem_req_o  (mem_req_o),
    .mem_op_o   (mem_op_o),
    .mem_key_o  (mem_key_o),
    .mem_data_o (mem_data_o),
    .mem_ack_i  (mem_ack_i),
    .mem_hit_i  (mem_hit_i),
    .mem_data_i (mem_data_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o),
    .timeout_o  (timeout_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    busy_o,    1'b0);
    chk({tag, ".req"},     mem_req_o, 1'b0);
    chk({tag, ".reg_o"},   reg_o,     '0);
    chk({tag, ".timeout"}, timeout_o, 1'b0);
    chk({tag, ".overrun"}, overrun_o, 1'b0);
  endtask

  // One operation from start pulse to the IDLE cycle after DONE.
  // ack_idx: REQ cycle (0-based) carrying the ack; ov_idx: REQ cycle with a
  // second start pulse.
  task automatic run_op(input string tag, input operation_e op,
                        input logic [RegKeyWidth-1:0] key,
                        input logic [RegDataWidth-1:0] wdata,
                        input int ack_idx, input logic hit,
                        input logic [RegDataWidth-1:0] rdata, input int ov_idx);
    bit         aborted;
    int         end_idx;
    reg_write_t e;
    reg_write_t busy_w;
    aborted = (ack_idx > AbortIdx);
    end_idx = aborted ? AbortIdx : ack_idx;
    e = '0;
    e.busy_valid      = 1'b1;
    e.hit_valid       = 1'b1;
    e.hit             = aborted ? 1'b0 : hit;
    e.operation       = NOOP;
    e.operation_valid = 1'b1;
    if (op == READ && !aborted) begin
      e.data_valid = 1'b1;
      e.dat        = hit ? rdata : '0;
    end
    busy_w = '0;
    busy_w.busy       = 1'b1;
    busy_w.busy_valid = 1'b1;

    @(negedge clk_i);
    start_i         = 1'b1;
    reg_i.operation = op;
    reg_i.key       = key;
    reg_i.dat       = wdata;
    exp_q.push_back(e);
    @(negedge clk_i);
    start_i         = 1'b0;
    reg_i.dat       = {$urandom, $urandom};
    reg_i.key       = $urandom;
    reg_i.operation = operation_e'($urandom_range(0, 3));
    for (int c = 0; c <= end_idx; c++) begin
      chk({tag, ".req"},      mem_req_o,  1'b1);
      chk({tag, ".busy"},     busy_o,     1'b1);
      chk({tag, ".mem_op"},   mem_op_o,   op);
      chk({tag, ".mem_key"},  mem_key_o,  key);
      chk({tag, ".mem_data"}, mem_data_o, wdata);
      chk({tag, ".timeout"},  timeout_o,  1'b0);
      chk({tag, ".overrun"},  overrun_o,  (c == ov_idx + 1));
      if (c == 0) chk({tag, ".busy_write"}, reg_o, busy_w);
      else        chk({tag, ".no_write"},   reg_o, '0);
      start_i = 1'b0;
      if (c == ack_idx) begin
        mem_ack_i  = 1'b1;
        mem_hit_i  = hit;
        mem_data_i = rdata;
      end else begin
        mem_ack_i  = 1'b0;
        mem_hit_i  = 1'($urandom);
        mem_data_i = {$urandom, $urandom};
      end
      if (c == ov_idx) begin
        start_i         = 1'b1;
        reg_i.operation = READ;
      end
      @(negedge clk_i);
    end
    mem_ack_i = 1'b0;
    start_i   = 1'b0;
    chk({tag, ".done_req"},     mem_req_o, 1'b0);
    chk({tag, ".done_busy"},    busy_o,    1'b1);
    chk({tag, ".done_timeout"}, timeout_o, aborted);
    chk({tag, ".done_overrun"}, overrun_o, (end_idx == ov_idx));
    chk({tag, ".done_op_kept"}, mem_op_o,  op);
    chk({tag, ".done_valid"},   reg_o.operation_valid, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".done_write"}, reg_o, e);
    end
    @(negedge clk_i);
    chk_idle({tag, ".idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    reg_i      = '0;
    mem_ack_i  = 1'b0;
    mem_hit_i  = 1'b0;
    mem_data_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk_idle("reset");
    chk("reset.mem_op",   mem_op_o,   NOOP);
    chk("reset.mem_key",  mem_key_o,  '0);
    chk("reset.mem_data", mem_data_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op("read_hit", READ, 32'h0000_0010, 64'h0, 0, 1'b1, 64'hDEADBEEF_CAFEF00D, NoOv);
    run_op("read_miss", READ, 32'h0000_0020, 64'h0, 3, 1'b0, 64'h1111_2222_3333_4444, NoOv);
    run_op("upsert", UPSERT, 32'h5, 64'h1234, 2, 1'b0, 64'hFFFF_0000_FFFF_0000, NoOv);
    run_op("delete_ov", DELETE, 32'hABCD, 64'h99, 2, 1'b1, 64'h5A5A, 0);
    run_op("upsert_hit", UPSERT, 32'h6, 64'h77, 1, 1'b1, 64'h0, NoOv);

    // NOOP start is ignored
    @(negedge clk_i);
    start_i         = 1'b1;
    reg_i.operation = NOOP;
    @(negedge clk_i);
    start_i = 1'b0;
    chk_idle("noop");

    // ack while idle is ignored
    mem_ack_i  = 1'b1;
    mem_hit_i  = 1'b1;
    mem_data_i = 64'h1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    chk_idle("idle_ack");

    // beyond the abort point: aborts with the feature, waits for ack without
    run_op("late_ack", READ, 32'h40, 64'h0, 6, 1'b1, 64'hC0FFEE, NoOv);
    run_op("ack_at_limit", UPSERT, 32'h41, 64'h42, T - 1, 1'b1, 64'h0, NoOv);
`ifdef CACHE_OP_SEQ_TIMEOUT_EN
    run_op("timeout", READ, 32'h50, 64'h0, NoAck, 1'b1, 64'hBAD, NoOv);
`endif

    // asynchronous reset in the middle of REQ
    @(negedge clk_i);
    start_i         = 1'b1;
    reg_i.operation = READ;
    reg_i.key       = 32'h77;
    reg_i.dat       = 64'h88;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("rst_mid.req_before", mem_req_o, 1'b1);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid.mem_op",  mem_op_o,  NOOP);
    chk("rst_mid.mem_key", mem_key_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("rst_after");
    run_op("read_after_rst", READ, 32'h0000_0010, 64'h0, 1, 1'b1, 64'h0123_4567_89AB_CDEF, NoOv);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
